// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish token sequencer driving a shift-register LIFO stack.
// Define RPN_STACK_CTRL_MUL_EN to make op 3 a multiply; otherwise op 3 is illegal.
//   state | meaning
//   IDLE  | accept tokens; PUSH/DROP finish here in one cycle
//   POP2  | first operand on stk_rdata, pop second operand
//   EXEC  | second operand on stk_rdata, push the ALU result
//   CAPT  | EMIT value on stk_rdata, register it as the result
module rpn_stack_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STACK_SIZE = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                tok_valid,
  output logic                                tok_ready,
  input  logic [2:0]                          tok_op,
  input  logic [DATA_WIDTH-1:0]               tok_data,
  output logic                                stk_push,
  output logic                                stk_pop,
  output logic [DATA_WIDTH-1:0]               stk_wdata,
  input  logic [DATA_WIDTH-1:0]               stk_rdata,
  output logic                                res_valid,
  output logic [DATA_WIDTH-1:0]               res_data,
  output logic [$clog2(STACK_SIZE+1)-1:0]     depth,
  output logic                                err,
  output logic [1:0]                          err_code
);

  localparam int DEPTH_W = $clog2(STACK_SIZE + 1);
  localparam logic [DEPTH_W-1:0] D_FULL = DEPTH_W'(STACK_SIZE);
  localparam logic [DEPTH_W-1:0] D_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] D_TWO  = DEPTH_W'(2);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_DROP = 3'd6;
  localparam logic [2:0] OP_EMIT = 3'd7;

  localparam logic [1:0] E_OVER  = 2'd1;
  localparam logic [1:0] E_UNDER = 2'd2;
  localparam logic [1:0] E_ILL   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_POP2, S_EXEC, S_CAPT} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              op_q, op_nxt;
  logic [DATA_WIDTH-1:0]   opr_a, opr_a_nxt;
  logic [DATA_WIDTH-1:0]   alu;
  logic [DEPTH_W-1:0]      depth_nxt;
  logic                    err_nxt;
  logic [1:0]              err_code_nxt;
  logic                    capt;
  logic                    accept;

  assign tok_ready = (state == S_IDLE) && !err && !rst;
  assign accept    = tok_valid && tok_ready;

  // B is the older entry, arriving on stk_rdata during EXEC; A was captured in POP2
  always_comb begin
    alu = '0;
    case (op_q)
      OP_ADD:  alu = stk_rdata + opr_a;
      OP_SUB:  alu = stk_rdata - opr_a;
      OP_AND:  alu = stk_rdata & opr_a;
      OP_XOR:  alu = stk_rdata ^ opr_a;
`ifdef RPN_STACK_CTRL_MUL_EN
      OP_MUL:  alu = stk_rdata * opr_a;
`endif
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    op_nxt       = op_q;
    opr_a_nxt    = opr_a;
    depth_nxt    = depth;
    err_nxt      = err;
    err_code_nxt = err_code;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_wdata    = '0;
    capt         = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (tok_op)
            OP_PUSH: begin
              if (depth < D_FULL) begin
                stk_push  = 1'b1;
                stk_wdata = tok_data;
                depth_nxt = depth + D_ONE;
              end else begin
                err_nxt      = 1'b1;
                err_code_nxt = E_OVER;
              end
            end
`ifdef RPN_STACK_CTRL_MUL_EN
            OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_MUL: begin
`else
            OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
`endif
              if (depth >= D_TWO) begin
                stk_pop   = 1'b1;
                op_nxt    = tok_op;
                state_nxt = S_POP2;
              end else begin
                err_nxt      = 1'b1;
                err_code_nxt = E_UNDER;
              end
            end
`ifndef RPN_STACK_CTRL_MUL_EN
            OP_MUL: begin
              err_nxt      = 1'b1;
              err_code_nxt = E_ILL;
            end
`endif
            OP_DROP, OP_EMIT: begin
              if (depth >= D_ONE) begin
                stk_pop = 1'b1;
                if (tok_op == OP_DROP) depth_nxt = depth - D_ONE;
                else                   state_nxt = S_CAPT;
              end else begin
                err_nxt      = 1'b1;
                err_code_nxt = E_UNDER;
              end
            end
            default: ;
          endcase
        end
      end
      S_POP2: begin
        stk_pop   = 1'b1;
        opr_a_nxt = stk_rdata;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        stk_push  = 1'b1;
        stk_wdata = alu;
        depth_nxt = depth - D_ONE;
        state_nxt = S_IDLE;
      end
      S_CAPT: begin
        capt      = 1'b1;
        depth_nxt = depth - D_ONE;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // the stack shares rst, so nothing may reach it while reset is asserted
    if (rst) begin
      stk_push = 1'b0;
      stk_pop  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_PUSH;
      opr_a     <= '0;
      depth     <= '0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      opr_a     <= opr_a_nxt;
      depth     <= depth_nxt;
      err       <= err_nxt;
      err_code  <= err_code_nxt;
      res_valid <= capt;
      if (capt) res_data <= stk_rdata;
    end
  end

endmodule
